// File: rtl/core161c_mem.sv
// core161c_mem: 16K x 36-bit core memory bank with four PDP-10 memory bus ports.
// Serves read, write and read-modify-write cycles one at a time, fixed priority p0 > p1 > p2 > p3.
module core161c_mem #(
   parameter logic [3:0] memsel_p0 = 4'b0,
   parameter logic [3:0] memsel_p1 = 4'b0,
   parameter logic [3:0] memsel_p2 = 4'b0,
   parameter logic [3:0] memsel_p3 = 4'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         power,
   input  logic         sw_single_step,
   input  logic         sw_restart,
   input  logic         membus_rq_cyc_p0,
   input  logic         membus_rd_rq_p0,
   input  logic         membus_wr_rq_p0,
   input  logic [18:21] membus_sel_p0,
   input  logic [21:35] membus_ma_p0,
   input  logic         membus_fmc_select_p0,
   input  logic         membus_wr_rs_p0,
   input  logic [0:35]  membus_mb_in_p0,
   output logic         membus_addr_ack_p0,
   output logic         membus_rd_rs_p0,
   output logic [0:35]  membus_mb_out_p0,
   input  logic         membus_rq_cyc_p1,
   input  logic         membus_rd_rq_p1,
   input  logic         membus_wr_rq_p1,
   input  logic [18:21] membus_sel_p1,
   input  logic [21:35] membus_ma_p1,
   input  logic         membus_fmc_select_p1,
   input  logic         membus_wr_rs_p1,
   input  logic [0:35]  membus_mb_in_p1,
   output logic         membus_addr_ack_p1,
   output logic         membus_rd_rs_p1,
   output logic [0:35]  membus_mb_out_p1,
   input  logic         membus_rq_cyc_p2,
   input  logic         membus_rd_rq_p2,
   input  logic         membus_wr_rq_p2,
   input  logic [18:21] membus_sel_p2,
   input  logic [21:35] membus_ma_p2,
   input  logic         membus_fmc_select_p2,
   input  logic         membus_wr_rs_p2,
   input  logic [0:35]  membus_mb_in_p2,
   output logic         membus_addr_ack_p2,
   output logic         membus_rd_rs_p2,
   output logic [0:35]  membus_mb_out_p2,
   input  logic         membus_rq_cyc_p3,
   input  logic         membus_rd_rq_p3,
   input  logic         membus_wr_rq_p3,
   input  logic [18:21] membus_sel_p3,
   input  logic [21:35] membus_ma_p3,
   input  logic         membus_fmc_select_p3,
   input  logic         membus_wr_rs_p3,
   input  logic [0:35]  membus_mb_in_p3,
   output logic         membus_addr_ack_p3,
   output logic         membus_rd_rs_p3,
   output logic [0:35]  membus_mb_out_p3
);

   localparam int unsigned NP    = 4;
   localparam int unsigned AW    = 14;
   localparam int unsigned DW    = 36;
   localparam int unsigned WORDS = 16384;

   typedef enum logic [3:0] {
      S_IDLE, S_ACK, S_RD, S_RS, S_RESTORE, S_WAIT_WR, S_WRITE, S_END, S_STOP
   } state_t;

   // Core array; preloadable from outside and deliberately untouched by reset.
   logic [0:DW-1] core [0:WORDS-1];

   logic [NP-1:0] w_qual;
   logic [NP-1:0] w_rd_rq;
   logic [NP-1:0] w_wr_rq;
   logic [NP-1:0] w_wr_rs;
   logic [AW-1:0] w_ma    [NP];
   logic [0:DW-1] w_mb_in [NP];
   logic [1:0]    w_port;
   logic          w_unused_ma21;

   state_t        r_state;
   logic [1:0]    r_port;
   logic [AW-1:0] r_addr;
   logic          r_rd;
   logic          r_wr;
   logic [0:DW-1] r_mb;
   logic          r_restart_d;
   logic [NP-1:0] r_addr_ack;
   logic [NP-1:0] r_rd_rs;
   logic [0:DW-1] r_mb_out [NP];

   assign w_qual[0] = power & membus_rq_cyc_p0 & (membus_sel_p0 == memsel_p0) &
                      ~membus_fmc_select_p0 & (membus_rd_rq_p0 | membus_wr_rq_p0);
   assign w_qual[1] = power & membus_rq_cyc_p1 & (membus_sel_p1 == memsel_p1) &
                      ~membus_fmc_select_p1 & (membus_rd_rq_p1 | membus_wr_rq_p1);
   assign w_qual[2] = power & membus_rq_cyc_p2 & (membus_sel_p2 == memsel_p2) &
                      ~membus_fmc_select_p2 & (membus_rd_rq_p2 | membus_wr_rq_p2);
   assign w_qual[3] = power & membus_rq_cyc_p3 & (membus_sel_p3 == memsel_p3) &
                      ~membus_fmc_select_p3 & (membus_rd_rq_p3 | membus_wr_rq_p3);

   assign w_rd_rq = {membus_rd_rq_p3, membus_rd_rq_p2, membus_rd_rq_p1, membus_rd_rq_p0};
   assign w_wr_rq = {membus_wr_rq_p3, membus_wr_rq_p2, membus_wr_rq_p1, membus_wr_rq_p0};
   assign w_wr_rs = {membus_wr_rs_p3, membus_wr_rs_p2, membus_wr_rs_p1, membus_wr_rs_p0};

   assign w_ma[0] = membus_ma_p0[22:35];
   assign w_ma[1] = membus_ma_p1[22:35];
   assign w_ma[2] = membus_ma_p2[22:35];
   assign w_ma[3] = membus_ma_p3[22:35];

   assign w_mb_in[0] = membus_mb_in_p0;
   assign w_mb_in[1] = membus_mb_in_p1;
   assign w_mb_in[2] = membus_mb_in_p2;
   assign w_mb_in[3] = membus_mb_in_p3;

   // Address bit 21 lies outside the 16K word range of this bank.
   assign w_unused_ma21 = membus_ma_p0[21] ^ membus_ma_p1[21] ^ membus_ma_p2[21] ^ membus_ma_p3[21];

   // Fixed-priority pick among qualifying ports, lowest port number wins.
   always_comb begin
      w_port = 2'd0;
      if (w_qual[0])      w_port = 2'd0;
      else if (w_qual[1]) w_port = 2'd1;
      else if (w_qual[2]) w_port = 2'd2;
      else if (w_qual[3]) w_port = 2'd3;
   end

   // Memory cycle sequencer with registered bus strobes and read data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_port      <= 2'd0;
         r_addr      <= '0;
         r_rd        <= 1'b0;
         r_wr        <= 1'b0;
         r_mb        <= '0;
         r_restart_d <= 1'b0;
         r_addr_ack  <= '0;
         r_rd_rs     <= '0;
         for (int i = 0; i < NP; i++) r_mb_out[i] <= '0;
      end else begin
         r_restart_d <= sw_restart;
         r_addr_ack  <= '0;
         r_rd_rs     <= '0;
         for (int i = 0; i < NP; i++) r_mb_out[i] <= '0;
         if (!power) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (|w_qual) begin
                     r_port             <= w_port;
                     r_addr             <= w_ma[w_port];
                     r_rd               <= w_rd_rq[w_port];
                     r_wr               <= w_wr_rq[w_port];
                     r_addr_ack[w_port] <= 1'b1;
                     r_state            <= S_ACK;
                  end
               end
               S_ACK: begin
                  r_mb    <= '0;
                  r_state <= r_rd ? S_RD : S_WAIT_WR;
               end
               S_RD: begin
                  r_mb             <= core[r_addr];
                  r_rd_rs[r_port]  <= 1'b1;
                  r_mb_out[r_port] <= core[r_addr];
                  r_state          <= S_RS;
               end
               S_RS: begin
                  if (r_wr) begin
                     r_state <= S_WAIT_WR;
                  end else begin
                     r_mb_out[r_port] <= r_mb;
                     r_state          <= S_RESTORE;
                  end
               end
               S_RESTORE: r_state <= S_END;
               S_WAIT_WR: begin
                  if (w_wr_rs[r_port]) begin
                     r_mb    <= w_mb_in[r_port];
                     r_state <= S_WRITE;
                  end
               end
               S_WRITE:   r_state <= S_END;
               S_END:     r_state <= sw_single_step ? S_STOP : S_IDLE;
               S_STOP: begin
                  if (sw_restart && !r_restart_d) r_state <= S_IDLE;
               end
               default:   r_state <= S_IDLE;
            endcase
         end
      end
   end

   // Core write-back: restore after a plain read, or store the write data.
   always_ff @(posedge clk) begin
      if (power && (r_state == S_RESTORE || r_state == S_WRITE)) core[r_addr] <= r_mb;
   end

   // Outputs are forced to zero the moment power drops.
   assign membus_addr_ack_p0 = power & r_addr_ack[0];
   assign membus_addr_ack_p1 = power & r_addr_ack[1];
   assign membus_addr_ack_p2 = power & r_addr_ack[2];
   assign membus_addr_ack_p3 = power & r_addr_ack[3];
   assign membus_rd_rs_p0    = power & r_rd_rs[0];
   assign membus_rd_rs_p1    = power & r_rd_rs[1];
   assign membus_rd_rs_p2    = power & r_rd_rs[2];
   assign membus_rd_rs_p3    = power & r_rd_rs[3];
   assign membus_mb_out_p0   = power ? r_mb_out[0] : DW'(0);
   assign membus_mb_out_p1   = power ? r_mb_out[1] : DW'(0);
   assign membus_mb_out_p2   = power ? r_mb_out[2] : DW'(0);
   assign membus_mb_out_p3   = power ? r_mb_out[3] : DW'(0);

endmodule

// File: tb/tb_core161c_mem.sv
// Directed bench for core161c_mem: read, write, RMW, qualification, priority, reset and single step.
module tb_core161c_mem;

   logic        clk = 1'b0;
   logic        reset;
   logic        power;
   logic        sw_ss;
   logic        sw_rst;
   logic        tb_rq   [4];
   logic        tb_rd   [4];
   logic        tb_wr   [4];
   logic        tb_fmc  [4];
   logic        tb_wrrs [4];
   logic [3:0]  tb_sel  [4];
   logic [13:0] tb_ma   [4];
   logic [35:0] tb_mbin [4];
   logic        w_ack   [4];
   logic        w_rs    [4];
   logic [35:0] w_mbout [4];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   core161c_mem dut (
      .clk(clk), .reset(reset), .power(power),
      .sw_single_step(sw_ss), .sw_restart(sw_rst),
      .membus_rq_cyc_p0(tb_rq[0]), .membus_rd_rq_p0(tb_rd[0]), .membus_wr_rq_p0(tb_wr[0]),
      .membus_sel_p0(tb_sel[0]), .membus_ma_p0({1'b0, tb_ma[0]}),
      .membus_fmc_select_p0(tb_fmc[0]), .membus_wr_rs_p0(tb_wrrs[0]), .membus_mb_in_p0(tb_mbin[0]),
      .membus_addr_ack_p0(w_ack[0]), .membus_rd_rs_p0(w_rs[0]), .membus_mb_out_p0(w_mbout[0]),
      .membus_rq_cyc_p1(tb_rq[1]), .membus_rd_rq_p1(tb_rd[1]), .membus_wr_rq_p1(tb_wr[1]),
      .membus_sel_p1(tb_sel[1]), .membus_ma_p1({1'b0, tb_ma[1]}),
      .membus_fmc_select_p1(tb_fmc[1]), .membus_wr_rs_p1(tb_wrrs[1]), .membus_mb_in_p1(tb_mbin[1]),
      .membus_addr_ack_p1(w_ack[1]), .membus_rd_rs_p1(w_rs[1]), .membus_mb_out_p1(w_mbout[1]),
      .membus_rq_cyc_p2(tb_rq[2]), .membus_rd_rq_p2(tb_rd[2]), .membus_wr_rq_p2(tb_wr[2]),
      .membus_sel_p2(tb_sel[2]), .membus_ma_p2({1'b0, tb_ma[2]}),
      .membus_fmc_select_p2(tb_fmc[2]), .membus_wr_rs_p2(tb_wrrs[2]), .membus_mb_in_p2(tb_mbin[2]),
      .membus_addr_ack_p2(w_ack[2]), .membus_rd_rs_p2(w_rs[2]), .membus_mb_out_p2(w_mbout[2]),
      .membus_rq_cyc_p3(tb_rq[3]), .membus_rd_rq_p3(tb_rd[3]), .membus_wr_rq_p3(tb_wr[3]),
      .membus_sel_p3(tb_sel[3]), .membus_ma_p3({1'b0, tb_ma[3]}),
      .membus_fmc_select_p3(tb_fmc[3]), .membus_wr_rs_p3(tb_wrrs[3]), .membus_mb_in_p3(tb_mbin[3]),
      .membus_addr_ack_p3(w_ack[3]), .membus_rd_rs_p3(w_rs[3]), .membus_mb_out_p3(w_mbout[3])
   );

   task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %o, expected %o", tag, obs, exp);
      end
   endtask

   // Counts negedges until port p acks; n = -1 if it never does within maxc.
   task automatic wait_ack(input int p, input int maxc, output int n);
      int i = 0;
      n = -1;
      while (n < 0 && i < maxc) begin
         @(negedge clk);
         i++;
         if (w_ack[p]) n = i;
      end
   endtask

   task automatic wait_rs(input int p, input int maxc, output int n);
      int i = 0;
      n = -1;
      while (n < 0 && i < maxc) begin
         @(negedge clk);
         i++;
         if (w_rs[p]) n = i;
      end
   endtask

   task automatic req(input int p, input logic [13:0] ma, input bit rd, input bit wr);
      tb_ma[p] = ma;
      tb_rd[p] = rd;
      tb_wr[p] = wr;
      tb_rq[p] = 1'b1;
   endtask

   task automatic drop(input int p);
      tb_rq[p] = 1'b0;
      tb_rd[p] = 1'b0;
      tb_wr[p] = 1'b0;
   endtask

   // One complete bus cycle from an idle bank; leaves the bank idle (or stopped) afterwards.
   task automatic do_cycle(input int p, input logic [13:0] ma, input bit rd, input bit wr,
                           input logic [35:0] wdata, input logic [35:0] exp_rd, input string tag);
      int n;
      req(p, ma, rd, wr);
      wait_ack(p, 20, n);
      check({tag, " ack latency"}, 36'(n), 36'd1);
      drop(p);
      if (rd) begin
         wait_rs(p, 10, n);
         check({tag, " rd_rs latency"}, 36'(n), 36'd2);
         check({tag, " read data"}, w_mbout[p], exp_rd);
      end
      if (wr) begin
         @(negedge clk);
         check({tag, " bus quiet in wait"}, w_mbout[p], 36'd0);
         tb_wrrs[p] = 1'b1;
         tb_mbin[p] = wdata;
         @(negedge clk);
         tb_wrrs[p] = 1'b0;
         tb_mbin[p] = 36'd0;
         repeat (2) @(negedge clk);
      end else begin
         @(negedge clk);
         check({tag, " restore data"}, w_mbout[p], exp_rd);
         repeat (2) @(negedge clk);
      end
   endtask

   // Applies a request on port 0 for 20 clocks and reports how many acks any port gave.
   task automatic count_acks(output int acks);
      acks = 0;
      req(0, 14'o300, 1'b1, 1'b0);
      repeat (20) begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) if (w_ack[k]) acks++;
      end
      drop(0);
   endtask

   int n;
   int acks;

   initial begin
      reset  = 1'b0;
      power  = 1'b1;
      sw_ss  = 1'b0;
      sw_rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tb_rq[k] = 0; tb_rd[k] = 0; tb_wr[k] = 0; tb_fmc[k] = 0; tb_wrrs[k] = 0;
         tb_sel[k] = 4'd0; tb_ma[k] = 14'd0; tb_mbin[k] = 36'd0;
      end
      dut.core[14'o300] = 36'o123456111222;
      dut.core[14'o141] = 36'o1;
      dut.core[14'o200] = 36'o0;

      // Held in reset, even a valid request gets no response.
      req(0, 14'o300, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      check("reset ack", 36'(w_ack[0]), 36'd0);
      check("reset rd_rs", 36'(w_rs[0]), 36'd0);
      check("reset mb_out", w_mbout[0], 36'd0);
      drop(0);
      reset = 1'b1;
      @(negedge clk);

      do_cycle(0, 14'o300, 1, 0, 36'd0, 36'o123456111222, "rd0300");
      check("core0300 kept", dut.core[14'o300], 36'o123456111222);

      do_cycle(0, 14'o200, 0, 1, 36'o777740000100, 36'd0, "wr0200");
      do_cycle(0, 14'o200, 1, 0, 36'd0, 36'o777740000100, "rd0200");

      do_cycle(0, 14'o141, 1, 1, 36'o2, 36'o1, "rmw0141");
      check("core0141 replaced", dut.core[14'o141], 36'o2);

      tb_fmc[0] = 1'b1;
      count_acks(acks);
      check("fmc ignored", 36'(acks), 36'd0);
      tb_fmc[0] = 1'b0;
      tb_sel[0] = 4'b0001;
      count_acks(acks);
      check("sel mismatch ignored", 36'(acks), 36'd0);
      tb_sel[0] = 4'b0000;
      power = 1'b0;
      count_acks(acks);
      check("power off ignored", 36'(acks), 36'd0);
      power = 1'b1;
      @(negedge clk);

      // p0 and p2 together: p0 first, p2 exactly at the earliest re-accept.
      req(0, 14'o300, 1'b1, 1'b0);
      req(2, 14'o200, 1'b1, 1'b0);
      wait_ack(0, 20, n);
      check("prio p0 first", 36'(n), 36'd1);
      check("prio p2 held", 36'(w_ack[2]), 36'd0);
      drop(0);
      wait_ack(2, 20, n);
      check("prio p2 after p0", 36'(n), 36'd6);
      drop(2);
      wait_rs(2, 10, n);
      check("p2 rd_rs latency", 36'(n), 36'd2);
      check("p2 read data", w_mbout[2], 36'o777740000100);
      check("p0 bus quiet", w_mbout[0], 36'd0);
      repeat (3) @(negedge clk);

      // Reset while waiting for write data, then a late wr_rs must not write.
      req(0, 14'o300, 1'b0, 1'b1);
      wait_ack(0, 20, n);
      check("wr3 ack latency", 36'(n), 36'd1);
      drop(0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midwr reset ack", 36'(w_ack[0]), 36'd0);
      check("midwr reset mb_out", w_mbout[0], 36'd0);
      @(negedge clk);
      reset = 1'b1;
      tb_wrrs[0] = 1'b1;
      tb_mbin[0] = 36'o7;
      @(negedge clk);
      tb_wrrs[0] = 1'b0;
      tb_mbin[0] = 36'd0;
      repeat (3) @(negedge clk);
      check("midwr core intact", dut.core[14'o300], 36'o123456111222);
      do_cycle(0, 14'o300, 1, 0, 36'd0, 36'o123456111222, "after reset");

      // Single step: second cycle waits for a sw_restart rising edge.
      sw_ss = 1'b1;
      do_cycle(0, 14'o141, 1, 0, 36'd0, 36'o2, "ss first");
      req(0, 14'o300, 1'b1, 1'b0);
      wait_ack(0, 10, n);
      check("ss halted", 36'(n), 36'(-1));
      sw_rst = 1'b1;
      wait_ack(0, 10, n);
      check("ss restart ack", 36'(n), 36'd2);
      drop(0);
      wait_rs(0, 10, n);
      check("ss read data", w_mbout[0], 36'o123456111222);
      repeat (3) @(negedge clk);
      sw_rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
